ascon_serial_host: RTL and testbench
====================================

ASCON_SERIAL_HOST -- requirements
Module: ascon_serial_host

Interface
REQ-001 Parameter Y, 80, message length in bits.
REQ-002 Parameter L, 256, hash output length in bits.
REQ-003 Parameter H, 256, core state/hash-width parameter; MAX = largest of H, L, Y (default 256).
REQ-004 Parameter START_CYCLES, 3, core start pulse width in cycles.
REQ-005 Parameter GAP_CYCLES, 2, idle cycles between ready seen and first hash bit sample.
REQ-006 Parameter TIMEOUT, 65535, max cycles waiting for core ready.
REQ-007 Parameter SEED, 32'hACE1_0001, LFSR seed; zero is replaced by 1.
REQ-008 clk  in  1  single clock, all logic on rising edge.
REQ-009 rst  in  1  synchronous, active-high reset.
REQ-010 in_valid  in  1; in_ready  out  1; in_message  in  Y: request handshake, message captured on in_valid && in_ready.
REQ-011 out_valid  out  1; out_ready  in  1: result handshake.
REQ-012 out_hash  out  L; out_timeout  out  1; out_cycles  out  32: hash, timeout flag, start-to-ready latency.
REQ-013 core_message  out  3; core_r64  out  7; core_rfault  out  1; core_start  out  1: drive the Ascon core serial inputs.
REQ-014 core_hash  in  1; core_ready  in  1: core serial hash bit and level ready.

Function
REQ-015 FSM states IDLE, LOAD, START, WAIT, GAP, READ, DONE; all transitions synchronous.
REQ-016 IDLE: in_ready=1; on handshake latch in_message, clear out_hash/out_timeout/out_cycles, go LOAD; all core_* outputs 0.
REQ-017 LOAD: exactly MAX cycles, index i = 0..MAX-1; core_message[0] = message[Y-1-i] for i<Y, 0 for i>=Y (MSB first).
REQ-018 LOAD: 32-bit Galois LFSR, taps 32'h80200003, advances every LOAD cycle; {core_rfault, core_r64, core_message[2:1]} = LFSR[9:0].
REQ-019 LFSR state persists across requests; only rst reloads SEED.
REQ-020 START: core_start=1 for exactly START_CYCLES cycles, core data outputs 0; cycle counter cleared to 0 on first START cycle.
REQ-021 Cycle counter increments every cycle from first START cycle through WAIT; saturates at 2^32-1.
REQ-022 WAIT: first cycle core_ready sampled 1 (in START or WAIT) -> out_cycles = counter value, go GAP.
REQ-023 WAIT: counter reaching TIMEOUT without ready -> out_timeout=1, out_hash=0, go DONE.
REQ-024 GAP: GAP_CYCLES cycles (0 allowed, skip state), then READ.
REQ-025 READ: MAX cycles; read cycle i samples core_hash into out_hash[i] for i<L; samples with i>=L discarded.
REQ-026 DONE: out_valid=1; out_hash/out_timeout/out_cycles stable until out_valid && out_ready, then IDLE next cycle.
REQ-027 in_ready=0 in every state except IDLE; in_valid outside IDLE ignored, no queuing.
REQ-028 core_ready ignored outside START/WAIT; ready already high at START entry counts as latency 0.

Reset
REQ-029 rst forces IDLE next edge from any state, including mid-LOAD/READ.
REQ-030 Reset values: in_ready=1, out_valid=0, out_hash=0, out_timeout=0, out_cycles=0, all core_* outputs 0, LFSR=SEED (or 1), counters 0.
REQ-031 rst overrides simultaneous in_valid; no request captured on a reset cycle.

Verification
REQ-032 Reset: rst 2 cycles -> all outputs at REQ-030 values; in_ready=1.
REQ-033 Load: in_message=80'h656e6372797074696f6e -> core_message[0] matches message MSB-first for 80 cycles, 0 for 176, LOAD lasts 256 cycles, core_start high exactly 3 cycles, LFSR bits match model.
REQ-034 Readout: core model raises ready 100 cycles after start rise, streams known 256-bit pattern after 2-cycle gap -> out_hash[i]=pattern bit i, out_cycles=100, out_timeout=0.
REQ-035 Timeout: core_ready held 0 -> out_valid after 65535 cycles with out_timeout=1, out_hash=0.
REQ-036 Backpressure: out_ready low 10 cycles in DONE, in_valid pulsed -> outputs stable, request ignored, IDLE one cycle after out_ready.
REQ-037 Mid-op reset: rst during READ cycle 50 -> IDLE next edge, core_start=0, out_valid=0, next request completes normally.

Source files
------------

// File: rtl/ascon_serial_host.sv
// Serial host for a bit-serial Ascon hash core: loads a message MSB-first with LFSR
// filler, pulses start, measures start-to-ready latency, then shifts the hash back in.
module ascon_serial_host #(
    parameter int          Y            = 80,
    parameter int          L            = 256,
    parameter int          H            = 256,
    parameter int          START_CYCLES = 3,
    parameter int          GAP_CYCLES   = 2,
    parameter int          TIMEOUT      = 65535,
    parameter logic [31:0] SEED         = 32'hACE1_0001
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [Y-1:0]   in_message,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [L-1:0]   out_hash,
    output logic           out_timeout,
    output logic [31:0]    out_cycles,
    output logic [2:0]     core_message,
    output logic [6:0]     core_r64,
    output logic           core_rfault,
    output logic           core_start,
    input  logic           core_hash,
    input  logic           core_ready
);

    localparam int          MAX        = (H >= L && H >= Y) ? H : ((L >= Y) ? L : Y);
    localparam int          IW         = (L > 1) ? $clog2(L) : 1;
    localparam logic [31:0] TAPS       = 32'h8020_0003;
    localparam logic [31:0] SEED_EFF   = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [31:0] LAST_SER   = 32'(MAX - 1);
    localparam logic [31:0] LAST_START = 32'(START_CYCLES - 1);
    localparam logic [31:0] LAST_GAP   = (GAP_CYCLES > 0) ? 32'(GAP_CYCLES - 1) : 32'h0;
    localparam logic [31:0] LAST_WAIT  = 32'(TIMEOUT - 1);
    localparam logic [31:0] L_U        = 32'(L);

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, GAP, READ, DONE} state_t;

    localparam state_t AFTER_READY = (GAP_CYCLES == 0) ? READ : GAP;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : 32'h0);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    state_t         state;
    logic [31:0]    idx;
    logic [31:0]    cyc;
    logic [31:0]    lfsr;
    logic [Y-1:0]   msg;
    logic           seen;

    // Core-facing outputs are registered one cycle ahead, so each LOAD cycle i
    // presents message bit Y-1-i and the LFSR state after i advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            cyc          <= '0;
            lfsr         <= SEED_EFF;
            msg          <= '0;
            seen         <= 1'b0;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            out_hash     <= '0;
            out_timeout  <= 1'b0;
            out_cycles   <= '0;
            core_message <= '0;
            core_r64     <= '0;
            core_rfault  <= 1'b0;
            core_start   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        msg          <= in_message << 1;
                        core_message <= {lfsr[1:0], in_message[Y-1]};
                        core_r64     <= lfsr[8:2];
                        core_rfault  <= lfsr[9];
                        lfsr         <= lfsr_step(lfsr);
                        out_hash     <= '0;
                        out_timeout  <= 1'b0;
                        out_cycles   <= '0;
                        in_ready     <= 1'b0;
                        idx          <= '0;
                        state        <= LOAD;
                    end
                end
                LOAD: begin
                    if (idx == LAST_SER) begin
                        core_message <= '0;
                        core_r64     <= '0;
                        core_rfault  <= 1'b0;
                        core_start   <= 1'b1;
                        cyc          <= '0;
                        seen         <= 1'b0;
                        idx          <= '0;
                        state        <= START;
                    end else begin
                        core_message <= {lfsr[1:0], msg[Y-1]};
                        core_r64     <= lfsr[8:2];
                        core_rfault  <= lfsr[9];
                        lfsr         <= lfsr_step(lfsr);
                        msg          <= msg << 1;
                        idx          <= idx + 32'd1;
                    end
                end
                START: begin
                    // Ready seen during the start pulse is latched but the pulse still runs full width.
                    cyc <= sat_inc(cyc);
                    if (core_ready && !seen) begin
                        out_cycles <= cyc;
                        seen       <= 1'b1;
                    end
                    if (idx == LAST_START) begin
                        core_start <= 1'b0;
                        idx        <= '0;
                        state      <= (seen || core_ready) ? AFTER_READY : WAIT;
                    end else begin
                        idx <= idx + 32'd1;
                    end
                end
                WAIT: begin
                    if (core_ready) begin
                        out_cycles <= cyc;
                        idx        <= '0;
                        state      <= AFTER_READY;
                    end else if (cyc >= LAST_WAIT) begin
                        out_timeout <= 1'b1;
                        out_hash    <= '0;
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cyc <= sat_inc(cyc);
                    end
                end
                GAP: begin
                    if (idx == LAST_GAP) begin
                        idx   <= '0;
                        state <= READ;
                    end else begin
                        idx <= idx + 32'd1;
                    end
                end
                READ: begin
                    if (idx < L_U)
                        out_hash[idx[IW-1:0]] <= core_hash;
                    if (idx == LAST_SER) begin
                        out_valid <= 1'b1;
                        idx       <= '0;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 32'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_serial_host.sv
// Directed bench for ascon_serial_host: reset, load/LFSR stream, readout, backpressure,
// mid-readout reset and core timeout, with a behavioural core driven from the stimulus.
module tb_ascon_serial_host;

    localparam int          Y    = 80;
    localparam int          L    = 256;
    localparam int          MAX  = 256;
    localparam logic [31:0] SEED = 32'hACE1_0001;

    localparam logic [79:0]  MSG1  = 80'h656e6372797074696f6e;
    localparam logic [79:0]  MSG2  = 80'h0123456789abcdef0011;
    localparam logic [255:0] PAT_A = {64'h0123456789abcdef, 64'hfedcba9876543210,
                                      64'hdeadbeefcafef00d, 64'h8000000000000001};
    localparam logic [255:0] PAT_B = {64'h00000000ffffffff, 64'h5555aaaa3333cccc,
                                      64'h0f0f0f0f12345678, 64'hffffffff00000000};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [Y-1:0]  in_message = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [L-1:0]  out_hash;
    logic          out_timeout;
    logic [31:0]   out_cycles;
    logic [2:0]    core_message;
    logic [6:0]    core_r64;
    logic          core_rfault;
    logic          core_start;
    logic          core_hash = 1'b0;
    logic          core_ready = 1'b0;

    int            passes = 0;
    int            total = 0;
    logic [31:0]   lfsr_m;

    ascon_serial_host #(
        .Y(80), .L(256), .H(256), .START_CYCLES(3), .GAP_CYCLES(2),
        .TIMEOUT(65535), .SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_message(in_message),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_hash(out_hash), .out_timeout(out_timeout), .out_cycles(out_cycles),
        .core_message(core_message), .core_r64(core_r64),
        .core_rfault(core_rfault), .core_start(core_start),
        .core_hash(core_hash), .core_ready(core_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lstep(input logic [31:0] s);
        logic [31:0] n;
        n = {1'b0, s[31:1]};
        if (s[0]) n = n ^ 32'h8020_0003;
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_outputs_idle(input string tag);
        check({tag, "_in_ready"},   in_ready, 1);
        check({tag, "_out_valid"},  out_valid, 0);
        check({tag, "_out_hash"},   out_hash, 0);
        check({tag, "_core_start"}, core_start, 0);
        check({tag, "_core_data"},  {core_message, core_r64, core_rfault}, 0);
    endtask

    task automatic do_request(input logic [79:0] msg, input logic [255:0] pat, input int delay,
                              input int abort_at, input string name);
        int   bad_msg, bad_lfsr, bad_start, bad_data, bad_vld, start_hi;
        logic exp_bit;
        core_ready = 1'b0;
        core_hash  = 1'b0;
        check({name, "_ready_idle"}, in_ready, 1);
        in_message = msg;
        in_valid   = 1'b1;
        tick();
        in_valid = 1'b0;
        check({name, "_ready_busy"}, in_ready, 0);
        bad_msg = 0; bad_lfsr = 0; bad_start = 0;
        for (int i = 0; i < MAX; i++) begin
            exp_bit = (i < Y) ? msg[Y-1-i] : 1'b0;
            if (core_message[0] !== exp_bit) bad_msg++;
            if ({core_rfault, core_r64, core_message[2:1]} !== lfsr_m[9:0]) bad_lfsr++;
            if (core_start !== 1'b0) bad_start++;
            lfsr_m = lstep(lfsr_m);
            tick();
        end
        check({name, "_load_msg_bad"},   bad_msg, 0);
        check({name, "_load_lfsr_bad"},  bad_lfsr, 0);
        check({name, "_load_start_bad"}, bad_start, 0);
        check({name, "_start_after_load"}, core_start, 1);
        start_hi = 0; bad_data = 0; bad_vld = 0;
        for (int k = 0; k <= delay + 2; k++) begin
            core_ready = (k >= delay);
            if (core_start === 1'b1) start_hi++;
            if ({core_message, core_r64, core_rfault} !== 11'h0) bad_data++;
            if (out_valid !== 1'b0) bad_vld++;
            tick();
        end
        check({name, "_start_width"}, start_hi, 3);
        check({name, "_start_data_bad"}, bad_data, 0);
        for (int i = 0; i < MAX; i++) begin
            core_hash = pat[i];
            if (out_valid !== 1'b0) bad_vld++;
            if (i == abort_at) begin
                rst        = 1'b1;
                in_valid   = 1'b1;
                in_message = MSG1;
                tick();
                rst      = 1'b0;
                in_valid = 1'b0;
                check_outputs_idle({name, "_rst"});
                lfsr_m = SEED;
                tick();
                check({name, "_no_capture"}, in_ready, 1);
                return;
            end
            tick();
        end
        check({name, "_early_valid_bad"}, bad_vld, 0);
        check({name, "_out_valid"},   out_valid, 1);
        check({name, "_out_hash"},    out_hash, pat);
        check({name, "_out_cycles"},  out_cycles, delay);
        check({name, "_out_timeout"}, out_timeout, 0);
        check({name, "_ready_done"},  in_ready, 0);
    endtask

    task automatic finish_req(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, "_ack_valid"}, out_valid, 0);
        check({name, "_ack_ready"}, in_ready, 1);
    endtask

    initial begin
        int bad_hold, offs;
        lfsr_m = SEED;

        rst = 1'b1;
        tick();
        tick();
        check_outputs_idle("reset");
        check("reset_timeout", out_timeout, 0);
        check("reset_cycles", out_cycles, 0);
        rst = 1'b0;
        tick();

        do_request(MSG1, PAT_A, 100, -1, "t1");

        bad_hold = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid   = (c == 3 || c == 4);
            in_message = MSG2;
            if (out_valid !== 1'b1 || out_hash !== PAT_A || out_cycles !== 32'd100 ||
                out_timeout !== 1'b0 || in_ready !== 1'b0) bad_hold++;
            tick();
        end
        in_valid = 1'b0;
        check("bp_hold_bad", bad_hold, 0);
        check("bp_still_valid", out_valid, 1);
        finish_req("bp");
        tick();
        check("bp_no_queue_ready", in_ready, 1);
        check("bp_no_queue_start", {core_message, core_r64, core_rfault, core_start}, 0);

        do_request(MSG2, PAT_B, 100, -1, "t2");
        finish_req("t2");

        do_request(MSG2, PAT_B, 100, 50, "abort");

        do_request(MSG1, PAT_A, 100, -1, "t4");
        finish_req("t4");

        core_ready = 1'b0;
        in_message = MSG2;
        in_valid   = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < MAX; i++) tick();
        offs = 0;
        while (out_valid !== 1'b1 && offs < 70000) begin
            tick();
            offs++;
        end
        check("to_latency", offs, 65535);
        check("to_flag", out_timeout, 1);
        check("to_hash", out_hash, 0);
        check("to_cycles", out_cycles, 0);
        finish_req("to");

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
